// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: turns SPI frames <cmd><data...> from spi_trx into register-bus
// burst writes or prefetching burst reads.
//   clk, rst          : clock, async active-high reset
//   trx_rst_i         : frame start from spi_trx
//   trx_data_i        : received byte, valid with trx_ack_pop_i
//   trx_data_o        : byte to transmit, loaded into spi_trx by trx_ack_o
//   reg_addr_o        : register address (holds between strobes)
//   reg_wdata_o       : write data, reg_we_o write strobe
//   reg_re_o          : read strobe, reg_rdata_i valid RD_LAT cycles later
//   err_o             : sticky read-overrun flag, cleared at frame start
module spi_reg_ctrl #(
  parameter int ADDR_W = 7,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trx_rst_i,
  input  logic [7:0]        trx_data_i,
  input  logic              trx_ack_pop_i,
  output logic [7:0]        trx_data_o,
  output logic              trx_ack_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic [7:0]        reg_wdata_o,
  output logic              reg_we_o,
  output logic              reg_re_o,
  input  logic [7:0]        reg_rdata_i,
  output logic              err_o
);

  typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [2:0]        RD_LOAD  = 3'(RD_LAT + 1);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        rd_cnt;
  logic              rd_busy;
  logic              rd_done;

  // Only one read is ever tracked: rd_cnt is loaded when a read is issued and
  // reaches 1 in the cycle its data is on reg_rdata_i. A newer read reloads it,
  // which is what discards the older one on overrun.
  assign rd_busy = (rd_cnt > 3'd1);
  assign rd_done = (rd_cnt == 3'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      addr        <= '0;
      rd_cnt      <= '0;
      trx_data_o  <= '0;
      trx_ack_o   <= 1'b0;
      reg_addr_o  <= '0;
      reg_wdata_o <= '0;
      reg_we_o    <= 1'b0;
      reg_re_o    <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      reg_we_o  <= 1'b0;
      reg_re_o  <= 1'b0;
      trx_ack_o <= 1'b0;
      if (rd_cnt != 3'd0) begin
        rd_cnt <= rd_cnt - 3'd1;
      end

      if (trx_rst_i) begin
        state  <= CMD;
        err_o  <= 1'b0;
        rd_cnt <= '0;
      end else begin
        if (rd_done) begin
          trx_ack_o  <= 1'b1;
          trx_data_o <= reg_rdata_i;
        end

        if (trx_ack_pop_i) begin
          case (state)
            IDLE: ;
            CMD: begin
              if (trx_data_i[7]) begin
                state      <= RD;
                reg_re_o   <= 1'b1;
                reg_addr_o <= trx_data_i[ADDR_W-1:0];
                addr       <= trx_data_i[ADDR_W-1:0] + ADDR_ONE;
                rd_cnt     <= RD_LOAD;
              end else begin
                state <= WR;
                addr  <= trx_data_i[ADDR_W-1:0];
              end
            end
            WR: begin
              reg_we_o    <= 1'b1;
              reg_addr_o  <= addr;
              reg_wdata_o <= trx_data_i;
              addr        <= addr + ADDR_ONE;
            end
            RD: begin
              if (rd_busy) begin
                err_o <= 1'b1;
              end
              reg_re_o   <= 1'b1;
              reg_addr_o <= addr;
              addr       <= addr + ADDR_ONE;
              rd_cnt     <= RD_LOAD;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule
